div_ctrl: RTL and testbench
===========================

# div_ctrl

Sequential 32-bit signed divider controller and datapath for the multi-cycle divide path. It drives the 64-bit remainder/quotient register (RQ register) and reads its full content back every cycle. It runs a 32-step restoring shift-subtract algorithm and then applies sign correction. It returns the quotient and remainder under a start/ready handshake.

## Interface
- No parameters; the width is fixed at 32/64 bits.
- clk  in  1  system clock; all state updates on the rising edge
- clr  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only in IDLE
- dividend  in  32  signed dividend; sampled with start
- divisor  in  32  signed divisor; sampled with start
- rq_q  in  64  current RQ register content (upper = partial remainder, lower = dividend/quotient bits)
- rq_upper  out  32  next upper half written to the RQ register
- rq_lower  out  32  next lower half written to the RQ register
- rq_ena  out  1  RQ register write enable
- busy  out  1  high in LOAD, ITER and FIX
- ready  out  1  one-cycle completion pulse (DONE state)
- quotient  out  32  signed result; held until the next completion
- remainder  out  32  signed result; held until the next completion
- div_zero  out  1  set with ready when divisor = 0; held with the results

## Operation
- States: IDLE, LOAD, ITER, FIX, DONE; the encoding is free.
- **IDLE**
  - On start=1, latch sign_q = dividend[31]^divisor[31], sign_r = dividend[31], a = |dividend|, b = |divisor| (32-bit unsigned magnitudes).
  - If divisor = 0: go to DONE with quotient=0, remainder=0, div_zero=1.
  - Otherwise go to LOAD.
  - start=0 keeps the block in IDLE.
- **LOAD:** rq_ena=1, rq_upper=0, rq_lower=a; clear the 5-bit iteration counter; go to ITER.
- **ITER (32 cycles):**
  - Compute t = {rq_q[62:0],1'b0} and d = {1'b0,t[63:32]} − {1'b0,b} (33-bit).
  - If d[32]=0: rq_upper=d[31:0], rq_lower={t[31:1],1'b1}.
  - Otherwise: rq_upper=t[63:32], rq_lower=t[31:0].
  - rq_ena=1 throughout. After the 32nd step (counter = 31), go to FIX.
- **FIX:**
  - rq_ena=0.
  - quotient = sign_q ? −rq_q[31:0] : rq_q[31:0].
  - remainder = sign_r ? −rq_q[63:32] : rq_q[63:32].
  - div_zero=0. Go to DONE.
- **DONE:** ready=1 for exactly one cycle, then IDLE. start is ignored here.
- Overflow case −2^31 / −1:
  - a = 0x80000000 is treated as unsigned.
  - The result wraps to quotient=0x80000000, remainder=0, div_zero=0. No special handling.
- Magnitude of −2^31 is 0x80000000, interpreted as unsigned.
- start while busy=1 is ignored; the operand inputs may change freely after the sampling edge.
- rq_ena=0 in IDLE, FIX and DONE, so the RQ content is preserved.

## Timing
- Reset (clr=0 at a rising edge) forces, from any state including mid-ITER:
  - state IDLE, counter 0;
  - quotient=0, remainder=0, div_zero=0;
  - ready=0, busy=0, rq_ena=0, rq_upper=0, rq_lower=0.
- rq_upper, rq_lower and rq_ena are combinational from state, latched operands and rq_q. The RQ register captures them on the same rising edge.
- Normal latency, counted from edge E0 where start is sampled in IDLE:
  - E1 writes the LOAD value;
  - E2..E33 perform the 32 iterations;
  - E34 registers the results;
  - ready=1 in the cycle after E34.
  - The next start can be sampled at E36; throughput is one divide per 36 cycles.
- Divide-by-zero: ready=1 in the cycle after E0; div_zero=1 at the same time.
- quotient, remainder and div_zero are registered and stable from the ready cycle until the next completion or reset.

## Test plan
- Basic: 100 / 7 → after 34 edges ready=1, quotient=14, remainder=2, div_zero=0; rq_ena high for exactly 33 cycles.
- Signs:
  - −100 / 7 → q=−14 (0xFFFFFFF2), r=−2.
  - 100 / −7 → q=−14, r=2.
  - −100 / −7 → q=14, r=−2.
- Divide by zero: 1234 / 0 → ready in the cycle after start, q=0, r=0, div_zero=1, rq_ena never asserted.
- Boundaries:
  - 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0.
  - 0x7FFFFFFF / 1 → q=0x7FFFFFFF, r=0.
  - 5 / 9 → q=0, r=5.
- Handshake: pulse start again mid-ITER with other operands → ignored, first result returned unchanged; held results persist through IDLE.
- Reset mid-operation: clr=0 at iteration 10 → next cycle all outputs 0, state IDLE; a new 100 / 7 then completes normally with q=14, r=2.

Source files
------------

// File: rtl/div_ctrl.sv
// Multi-cycle 32-bit signed divider: restoring shift-subtract on an external
// 64-bit RQ register, followed by sign correction of quotient and remainder.
module div_ctrl (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic [63:0] rq_q,
    output logic [31:0] rq_upper,
    output logic [31:0] rq_lower,
    output logic        rq_ena,
    output logic        busy,
    output logic        ready,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  count;
    logic        sign_q;
    logic        sign_r;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] dividend_mag;
    logic [31:0] divisor_mag;
    logic [31:0] t_upper;
    logic [32:0] d;

    // Two's-complement magnitude; -2^31 maps to 0x80000000 read as unsigned.
    assign dividend_mag = dividend[31] ? (~dividend + 32'd1) : dividend;
    assign divisor_mag  = divisor[31]  ? (~divisor + 32'd1)  : divisor;

    // Upper half of the RQ content shifted left by one; d[32] flags a borrow.
    assign t_upper = rq_q[62:31];
    assign d       = {1'b0, t_upper} - {1'b0, b};

    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (divisor == 32'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD:  state_nxt = S_ITER;
            S_ITER:  state_nxt = (count == 5'd31) ? S_FIX : S_ITER;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            count     <= 5'd0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            a         <= 32'd0;
            b         <= 32'd0;
            quotient  <= 32'd0;
            remainder <= 32'd0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sign_q <= dividend[31] ^ divisor[31];
                        sign_r <= dividend[31];
                        a      <= dividend_mag;
                        b      <= divisor_mag;
                        if (divisor == 32'd0) begin
                            quotient  <= 32'd0;
                            remainder <= 32'd0;
                            div_zero  <= 1'b1;
                        end
                    end
                end
                S_LOAD: count <= 5'd0;
                S_ITER: count <= count + 5'd1;
                S_FIX: begin
                    quotient  <= sign_q ? (~rq_q[31:0] + 32'd1) : rq_q[31:0];
                    remainder <= sign_r ? (~rq_q[63:32] + 32'd1) : rq_q[63:32];
                    div_zero  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rq_upper = 32'd0;
        rq_lower = 32'd0;
        rq_ena   = 1'b0;
        busy     = 1'b0;
        ready    = 1'b0;
        case (state)
            S_LOAD: begin
                rq_ena   = 1'b1;
                rq_lower = a;
                busy     = 1'b1;
            end
            S_ITER: begin
                rq_ena = 1'b1;
                busy   = 1'b1;
                if (!d[32]) begin
                    rq_upper = d[31:0];
                    rq_lower = {rq_q[30:0], 1'b1};
                end else begin
                    rq_upper = t_upper;
                    rq_lower = {rq_q[30:0], 1'b0};
                end
            end
            S_FIX:   busy  = 1'b1;
            S_DONE:  ready = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: models the external RQ register, drives divides and
// checks results against a reference divide through an expected queue.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [63:0] rq_q = 64'd0;
    logic [31:0] rq_upper;
    logic [31:0] rq_lower;
    logic        rq_ena;
    logic        busy;
    logic        ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int n_checks = 0;
    int n_fail   = 0;
    logic [64:0] exp_q[$];

    div_ctrl dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .rq_q      (rq_q),
        .rq_upper  (rq_upper),
        .rq_lower  (rq_lower),
        .rq_ena    (rq_ena),
        .busy      (busy),
        .ready     (ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // External RQ register
    always @(posedge clk) begin
        if (rq_ena) rq_q <= {rq_upper, rq_lower};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {div_zero, quotient, remainder}, C-style truncating division
    function automatic logic [64:0] model(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] ax, by, qm, rm, q, r;
        if (y == 32'd0) return {1'b1, 64'd0};
        ax = x[31] ? (~x + 32'd1) : x;
        by = y[31] ? (~y + 32'd1) : y;
        qm = ax / by;
        rm = ax % by;
        q  = (x[31] ^ y[31]) ? (~qm + 32'd1) : qm;
        r  = x[31] ? (~rm + 32'd1) : rm;
        return {1'b0, q, r};
    endfunction

    always @(negedge clk) begin
        if (clr && ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_ready", 64'd1, 64'd0);
            end else begin
                logic [64:0] e;
                e = exp_q.pop_front();
                check("quotient", {32'd0, quotient}, {32'd0, e[63:32]});
                check("remainder", {32'd0, remainder}, {32'd0, e[31:0]});
                check("div_zero", {63'd0, div_zero}, {63'd0, e[64]});
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {27'd0, ready, busy, rq_ena, div_zero, 1'b0, 32'd0}, 64'd0);
        check({tag, "_rq"}, {rq_upper, rq_lower}, 64'd0);
        check({tag, "_results"}, {quotient, remainder}, 64'd0);
    endtask

    // Drive one divide; optionally poke start mid-run or reset at a given cycle.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int exp_lat,
                          input int exp_ena, input int poke_at, input int reset_at);
        int cyc = 0;
        int ena = 0;
        @(negedge clk);
        start    = 1'b1;
        dividend = x;
        divisor  = y;
        if (reset_at < 0) exp_q.push_back(model(x, y));
        while (1) begin
            @(negedge clk);
            cyc++;
            start    = (cyc == poke_at);
            dividend = $urandom;
            divisor  = $urandom_range(1, 50);
            if (rq_ena) ena++;
            if (cyc == 12) check("busy_mid", {63'd0, busy}, {63'd0, (exp_lat > 1) ? 1'b1 : 1'b0});
            if (cyc == reset_at) begin
                clr = 1'b0;
                @(negedge clk);
                start = 1'b0;
                check_all_zero("mid_reset");
                clr = 1'b1;
                return;
            end
            if (ready || cyc > 60) break;
        end
        check("latency", 64'(cyc), 64'(exp_lat));
        check("rq_ena_cycles", 64'(ena), 64'(exp_ena));
    endtask

    initial begin
        clr      = 1'b0;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        clr = 1'b1;

        run_op(32'd100, 32'd7, 35, 33, -1, -1);
        run_op(32'(-100), 32'd7, 35, 33, -1, -1);
        run_op(32'd100, 32'(-7), 35, 33, -1, -1);
        run_op(32'(-100), 32'(-7), 35, 33, -1, -1);
        run_op(32'd1234, 32'd0, 1, 0, -1, -1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 35, 33, -1, -1);
        run_op(32'h7FFF_FFFF, 32'd1, 35, 33, -1, -1);
        run_op(32'd5, 32'd9, 35, 33, -1, -1);
        run_op(32'h8000_0000, 32'd1, 35, 33, -1, -1);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = 32'($urandom_range(1, 1000));
            if ($urandom_range(0, 1) == 1) y = ~y + 32'd1;
            run_op(x, y, 35, 33, -1, -1);
        end

        // Start pulse during iteration must not disturb the running divide
        run_op(32'd100, 32'd7, 35, 33, 10, -1);
        repeat (5) @(negedge clk);
        check("hold_ready", {63'd0, ready}, 64'd0);
        check("hold_results", {quotient, remainder}, {32'd14, 32'd2});

        run_op(32'd100, 32'd7, 35, 33, -1, 12);
        run_op(32'd100, 32'd7, 35, 33, -1, -1);

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
